// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus bundle (imem request/ack, redirect, decode valid/ready)
// Signals:
//   imemReq/imemAddr     fetch -> memory word read request and address
//   imemAck/imemRdata    memory -> fetch completion and instruction word
//   redirect/redirectPc  execute -> fetch one-cycle restart pulse and target
//   instrValid/instrReady fetch <-> decode handshake
//   instr/pc             buffered instruction and its address
//   opcode/rd/rs1/rs2    raw fields sliced from instr
//   misalign             one-cycle pulse for a redirect target with low bits set
// Modports: master = fetch stage, slave = its environment.
interface instruction_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        misalign;
  modport master (
    output imemReq, imemAddr, instrValid, instr, pc, opcode, rd, rs1, rs2, misalign,
    input  imemAck, imemRdata, redirect, redirectPc, instrReady
  );
  modport slave (
    input  imemReq, imemAddr, instrValid, instr, pc, opcode, rd, rs1, rs2, misalign,
    output imemAck, imemRdata, redirect, redirectPc, instrReady
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage -- owns the PC, reads imem, buffers one instruction for decode
// Ports:
//   clk   rising-edge clock
//   rstN  asynchronous active-low reset
//   bus   instruction_fetch_if.master (imem request/ack, redirect, decode handshake, fields)
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 rstN,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} stateT;
  stateT       state;
  logic [31:0] fetchPc;
  logic [31:0] reqAddr;
  logic [31:0] instrReg;
  logic [31:0] pcReg;
  logic        reqReg;
  logic        validReg;
  logic        misReg;
  logic [31:0] target;
  logic [31:0] nextPc;
  assign target = {bus.redirectPc[31:2], 2'b00};
  // Address of the next request to issue: a redirect in this cycle always wins.
  assign nextPc = bus.redirect ? target : fetchPc;
  assign bus.imemReq    = reqReg;
  assign bus.imemAddr   = reqAddr;
  assign bus.instrValid = validReg;
  assign bus.instr      = instrReg;
  assign bus.pc         = pcReg;
  assign bus.opcode     = instrReg[6:0];
  assign bus.rd         = instrReg[11:7];
  assign bus.rs1        = instrReg[19:15];
  assign bus.rs2        = instrReg[24:20];
  assign bus.misalign   = misReg;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      fetchPc  <= RESET_PC;
      reqAddr  <= RESET_PC;
      reqReg   <= 1'b0;
      validReg <= 1'b0;
      instrReg <= NOP_INSTR;
      pcReg    <= RESET_PC;
      misReg   <= 1'b0;
    end else begin
      misReg <= bus.redirect & |bus.redirectPc[1:0];
      case (state)
        IDLE: begin
          state   <= REQ;
          reqReg  <= 1'b1;
          fetchPc <= nextPc;
          reqAddr <= nextPc;
        end
        REQ: begin
          if (bus.imemAck && bus.redirect) begin
            // Returned word is wrong-path; reissue immediately at the target.
            fetchPc <= target;
            reqAddr <= target;
          end else if (bus.imemAck) begin
            instrReg <= bus.imemRdata;
            pcReg    <= fetchPc;
            validReg <= 1'b1;
            fetchPc  <= fetchPc + 32'd4;
            reqReg   <= 1'b0;
            state    <= HOLD;
          end else if (bus.redirect) begin
            // Request stays on the bus with its old address until memory answers.
            fetchPc <= target;
            state   <= DROP;
          end
        end
        DROP: begin
          if (bus.imemAck) begin
            fetchPc <= nextPc;
            reqAddr <= nextPc;
            state   <= REQ;
          end else if (bus.redirect) begin
            fetchPc <= target;
          end
        end
        HOLD: begin
          // Redirect squashes the buffered word even if decode is ready.
          if (bus.redirect || bus.instrReady) begin
            validReg <= 1'b0;
            instrReg <= NOP_INSTR;
            reqReg   <= 1'b1;
            fetchPc  <= nextPc;
            reqAddr  <= nextPc;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench with a transaction-level fetch model and per-cycle compare
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  instruction_fetch_if bus ();
  instruction_fetch dut (.clk(clk), .rstN(rstN), .bus(bus));
  always #5 clk = ~clk;
  // Model: is a read on the bus, is it going to be thrown away, what to fetch next,
  // and what the one-entry buffer holds.
  logic        mStarted, mBusy, mDrop, mValid, mMis;
  logic [31:0] mNext, mAddr, mInstr, mPc;
  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mStarted <= 1'b0; mBusy <= 1'b0; mDrop <= 1'b0; mValid <= 1'b0; mMis <= 1'b0;
      mNext <= 32'h0; mAddr <= 32'h0; mInstr <= NOP; mPc <= 32'h0;
    end else begin
      mMis <= bus.redirect && bus.redirectPc[1:0] != 2'b00;
      if (!mStarted) begin
        mStarted <= 1'b1;
        mBusy    <= 1'b1;
        mNext    <= bus.redirect ? align(bus.redirectPc) : mNext;
        mAddr    <= bus.redirect ? align(bus.redirectPc) : mNext;
      end else if (mBusy) begin
        if (bus.imemAck && !mDrop && !bus.redirect) begin
          mValid <= 1'b1;
          mInstr <= bus.imemRdata;
          mPc    <= mAddr;
          mNext  <= mAddr + 32'd4;
          mBusy  <= 1'b0;
        end else if (bus.imemAck) begin
          mDrop <= 1'b0;
          mNext <= bus.redirect ? align(bus.redirectPc) : mNext;
          mAddr <= bus.redirect ? align(bus.redirectPc) : mNext;
        end else if (bus.redirect) begin
          mDrop <= 1'b1;
          mNext <= align(bus.redirectPc);
        end
      end else if (bus.redirect || bus.instrReady) begin
        mValid <= 1'b0;
        mInstr <= NOP;
        mBusy  <= 1'b1;
        mNext  <= bus.redirect ? align(bus.redirectPc) : mNext;
        mAddr  <= bus.redirect ? align(bus.redirectPc) : mNext;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rstN) begin
      chk("req", 32'(bus.imemReq), 32'(mBusy));
      if (mBusy || !mStarted) chk("addr", bus.imemAddr, mAddr);
      chk("valid", 32'(bus.instrValid), 32'(mValid));
      chk("instr", bus.instr, mInstr);
      chk("pc", bus.pc, mPc);
      chk("opcode", 32'(bus.opcode), 32'(mInstr[6:0]));
      chk("rd", 32'(bus.rd), 32'(mInstr[11:7]));
      chk("rs1", 32'(bus.rs1), 32'(mInstr[19:15]));
      chk("rs2", 32'(bus.rs2), 32'(mInstr[24:20]));
      chk("misalign", 32'(bus.misalign), 32'(mMis));
    end
  end
  task automatic cyc(input logic a, input logic [31:0] d, input logic r, input logic [31:0] t, input logic rdy);
    bus.imemAck = a;
    bus.imemRdata = d;
    bus.redirect = r;
    bus.redirectPc = t;
    bus.instrReady = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chkReset(input string tag);
    chk({tag, "_req"}, 32'(bus.imemReq), 32'h0);
    chk({tag, "_addr"}, bus.imemAddr, 32'h0);
    chk({tag, "_valid"}, 32'(bus.instrValid), 32'h0);
    chk({tag, "_instr"}, bus.instr, 32'h0000_0013);
    chk({tag, "_pc"}, bus.pc, 32'h0);
    chk({tag, "_opcode"}, 32'(bus.opcode), 32'h13);
    chk({tag, "_rd"}, 32'(bus.rd), 32'h0);
    chk({tag, "_rs1"}, 32'(bus.rs1), 32'h0);
    chk({tag, "_rs2"}, 32'(bus.rs2), 32'h0);
    chk({tag, "_mis"}, 32'(bus.misalign), 32'h0);
  endtask
  initial begin
    bus.imemAck = 1'b0; bus.imemRdata = 32'h0; bus.redirect = 1'b0;
    bus.redirectPc = 32'h0; bus.instrReady = 1'b0;
    repeat (2) @(negedge clk);
    chkReset("rst");
    rstN = 1'b1;
    repeat (4) cyc(mBusy, 32'h0010_0093, 1'b0, 32'h0, 1'b1);
    chk("lit_valid_pc4", 32'(bus.instrValid), 32'h1);
    chk("lit_pc4", bus.pc, 32'h4);
    chk("lit_rd1", 32'(bus.rd), 32'h1);
    chk("lit_op13", 32'(bus.opcode), 32'h13);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("lit_addr8", bus.imemAddr, 32'h8);
    cyc(1'b1, 32'h0020_0113, 1'b0, 32'h0, 1'b0);
    repeat (5) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("lit_hold_pc8", bus.pc, 32'h8);
    chk("lit_hold_instr", bus.instr, 32'h0020_0113);
    chk("lit_hold_rd2", 32'(bus.rd), 32'h2);
    chk("lit_hold_noreq", 32'(bus.imemReq), 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("lit_addrC", bus.imemAddr, 32'hC);
    chk("lit_nop_after_xfer", bus.instr, 32'h0000_0013);
    cyc(1'b1, 32'h0010_0093, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("lit_drop_addr10", bus.imemAddr, 32'h10);
    chk("lit_drop_req", 32'(bus.imemReq), 32'h1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    chk("lit_drop_novalid", 32'(bus.instrValid), 32'h0);
    chk("lit_addr100", bus.imemAddr, 32'h100);
    cyc(1'b1, 32'h0030_0193, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    chk("lit_squash_valid", 32'(bus.instrValid), 32'h0);
    chk("lit_squash_nop", bus.instr, 32'h0000_0013);
    chk("lit_squash_pc", bus.pc, 32'h100);
    chk("lit_addr200", bus.imemAddr, 32'h200);
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b1);
    chk("lit_mis_pulse", 32'(bus.misalign), 32'h1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    chk("lit_mis_end", 32'(bus.misalign), 32'h0);
    chk("lit_mis_addr100", bus.imemAddr, 32'h100);
    cyc(1'b1, 32'hCAFE_F00D, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("lit_addr_top", bus.imemAddr, 32'hFFFF_FFFC);
    chk("lit_ackredir_novalid", 32'(bus.instrValid), 32'h0);
    cyc(1'b1, 32'h0040_0213, 1'b0, 32'h0, 1'b1);
    chk("lit_pc_top", bus.pc, 32'hFFFF_FFFC);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("lit_wrap_addr0", bus.imemAddr, 32'h0);
    cyc(1'b1, 32'h0050_0293, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h0060_0313, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h401, 1'b1);
    cyc(1'b1, 32'h0, 1'b1, 32'h500, 1'b1);
    chk("lit_addr500", bus.imemAddr, 32'h500);
    chk("lit_pc4_before_rst", bus.pc, 32'h4);
    #2 rstN = 1'b0;
    #1 chkReset("async");
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) cyc(mBusy, 32'h0010_0093, 1'b0, 32'h0, 1'b1);
    chk("lit_restart_pc4", bus.pc, 32'h4);
    chk("lit_restart_valid", 32'(bus.instrValid), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
